// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - grid-derived constants, LFSR tap table and shared types for row bias logic
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package sudoku_pkg;

  localparam int GRID_LEN = `GRID_LEN;
  localparam int IDX_W    = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  typedef enum logic {IDLE, SHUFFLE} bias_state_t;
  typedef logic [GRID_LEN-1:0] onehot_t;

  // Maximal-length Galois tap masks for the widths the grid logic uses.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      16:      lfsr_taps = {16'h0000, LFSR_TAPS_16};
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'hA300_0000;
      default: lfsr_taps = {16'h0000, LFSR_TAPS_16};
    endcase
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - right-shifting Galois LFSR that advances only while enabled
module lfsr_galois #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] state
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [LFSR_W-1:0] SEED_NZ =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (enable) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED_NZ;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/row_bias_bank.sv
// rtl/row_bias_bank.sv - one row's one-hot value permutation with LFSR Fisher-Yates reshuffle
module row_bias_bank
  import sudoku_pkg::*;
#(
  parameter int                GRID_LEN = `GRID_LEN,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [GRID_LEN:0]   rqindex,
  input  logic                updaterowbias,
  output logic [GRID_LEN-1:0] rowbias,
  output logic                ready
);

  localparam int IW = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(GRID_LEN - 1);
  localparam logic [31:0]   TAPS_ALL = lfsr_taps(LFSR_W);

  bias_state_t         state_q;
  logic [IW-1:0]       idx_q;
  logic                pending_q;
  logic                ready_q;
  logic [GRID_LEN-1:0] rowbias_q;
  logic [GRID_LEN-1:0] rowbias_d;
  logic [GRID_LEN-1:0] slot_q [GRID_LEN];

  logic [LFSR_W-1:0]   lfsr;
  logic [IW-1:0]       j;
  logic                accept;

  lfsr_galois #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS_ALL[LFSR_W-1:0]),
    .SEED   (SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == SHUFFLE),
    .state  (lfsr)
  );

  // Rejection sampling: a draw above the current index (including any
  // index beyond GRID_LEN-1) is discarded rather than folded, keeping it unbiased.
  assign j      = lfsr[IW-1:0];
  assign accept = (j <= idx_q);

  always_comb begin
    rowbias_d = '0;
    for (int k = GRID_LEN - 1; k >= 0; k--) begin
      if (rqindex[k]) begin
        rowbias_d = slot_q[k];
      end
    end
    if (state_q != IDLE || rqindex == '0) begin
      rowbias_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      rowbias_q <= '0;
      for (int k = 0; k < GRID_LEN; k++) begin
        slot_q[k] <= {{(GRID_LEN-1){1'b0}}, 1'b1} << k;
      end
    end else begin
      rowbias_q <= rowbias_d;
      case (state_q)
        IDLE: begin
          if (updaterowbias) begin
            state_q <= SHUFFLE;
            idx_q   <= I_TOP;
            ready_q <= 1'b0;
          end
        end
        SHUFFLE: begin
          if (updaterowbias) begin
            pending_q <= 1'b1;
          end
          if (accept) begin
            slot_q[idx_q] <= slot_q[j];
            slot_q[j]     <= slot_q[idx_q];
            if (idx_q == IW'(1)) begin
              // A pulse landing on the final step counts as pending.
              if (pending_q || updaterowbias) begin
                pending_q <= 1'b0;
                idx_q     <= I_TOP;
              end else begin
                state_q <= IDLE;
                ready_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q - IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rowbias = rowbias_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_row_bias_bank.sv
// tb/tb_row_bias_bank.sv - directed self-checking bench for row_bias_bank with a shuffle model
module tb_row_bias_bank;

  localparam int GL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          updaterowbias;
  logic [GL:0]   rqindex;
  logic [GL-1:0] rowbias;
  logic          ready;

  int checks = 0;
  int errors = 0;

  logic [15:0]   m_lfsr;
  logic [GL-1:0] m_slot [GL];
  logic [255:0]  seen;

  row_bias_bank #(.GRID_LEN(GL), .LFSR_W(16), .SEED(16'hACE1)) dut (
    .clock         (clock),
    .reset         (reset),
    .rqindex       (rqindex),
    .updaterowbias (updaterowbias),
    .rowbias       (rowbias),
    .ready         (ready)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset;
    m_lfsr = 16'hACE1;
    for (int k = 0; k < GL; k++) m_slot[k] = 4'b0001 << k;
  endtask

  task automatic m_shuffle(output int steps);
    int i;
    logic [1:0] jj;
    logic [GL-1:0] t;
    i = GL - 1;
    steps = 0;
    for (int n = 0; n < 1000 && i >= 1; n++) begin
      jj = m_lfsr[1:0];
      steps++;
      if (int'(jj) <= i) begin
        t = m_slot[i];
        m_slot[i] = m_slot[jj];
        m_slot[jj] = t;
        i--;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic start_shuffle;
    rqindex = '0;
    updaterowbias = 1'b1;
    tick;
    updaterowbias = 1'b0;
    rqindex = 5'b00001;
  endtask

  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 16 * GL) begin
      tick;
      cycles++;
      if (ready !== 1'b1) check({tag, "_rowbias_zero"}, 32'(rowbias), 32'h0);
    end
    check({tag, "_ready_rise"}, 32'(ready), 32'h1);
  endtask

  task automatic read_slot(input int k, output logic [GL-1:0] v);
    rqindex = 5'b00001 << k;
    tick;
    v = rowbias;
  endtask

  initial begin
    logic [GL-1:0] v [GL];
    logic [GL-1:0] acc;
    logic [7:0]    code;
    int cyc, s1, s2, nperm;
    bit ok;

    reset = 1'b1;
    updaterowbias = 1'b0;
    rqindex = '0;
    m_reset();
    tick;
    tick;
    check("reset_ready", 32'(ready), 32'h1);
    check("reset_rowbias", 32'(rowbias), 32'h0);
    reset = 1'b0;
    tick;

    rqindex = 5'b00100; tick;
    check("read_slot2", 32'(rowbias), 32'h4);
    check("read_ready", 32'(ready), 32'h1);
    rqindex = 5'b10000; tick;
    check("read_past_end", 32'(rowbias), 32'h0);
    rqindex = 5'b00000; tick;
    check("read_none", 32'(rowbias), 32'h0);
    rqindex = 5'b00110; tick;
    check("read_multihot", 32'(rowbias), 32'h2);

    // First shuffle from SEED 0xACE1: j draws 1,0,0 all accepted -> {8,4,1,2} in 3 cycles.
    start_shuffle();
    check("shuf1_ready_low", 32'(ready), 32'h0);
    check("shuf1_rowbias_low", 32'(rowbias), 32'h0);
    m_shuffle(s1);
    wait_ready("shuf1", cyc);
    check("shuf1_cycles_hand", 32'(cyc), 32'd3);
    check("shuf1_cycles_model", 32'(cyc), 32'(s1));
    for (int k = 0; k < GL; k++) read_slot(k, v[k]);
    check("shuf1_slot0", 32'(v[0]), 32'h8);
    check("shuf1_slot1", 32'(v[1]), 32'h4);
    check("shuf1_slot2", 32'(v[2]), 32'h1);
    check("shuf1_slot3", 32'(v[3]), 32'h2);
    acc = v[0] | v[1] | v[2] | v[3];
    check("shuf1_or", 32'(acc), 32'hF);
    for (int k = 0; k < GL; k++) check("shuf1_model", 32'(v[k]), 32'(m_slot[k]));

    // Two extra pulses mid-shuffle collapse into one chained shuffle.
    start_shuffle();
    updaterowbias = 1'b1;
    tick;
    check("dbl_ready_low1", 32'(ready), 32'h0);
    tick;
    check("dbl_ready_low2", 32'(ready), 32'h0);
    updaterowbias = 1'b0;
    m_shuffle(s1);
    m_shuffle(s2);
    wait_ready("dbl", cyc);
    check("dbl_cycles", 32'(cyc), 32'(s1 + s2 - 2));
    for (int k = 0; k < GL; k++) begin
      read_slot(k, v[k]);
      check("dbl_model", 32'(v[k]), 32'(m_slot[k]));
    end

    // Reset two cycles into a shuffle.
    start_shuffle();
    tick;
    tick;
    check("mid_ready_low", 32'(ready), 32'h0);
    reset = 1'b1;
    #1;
    check("mid_reset_ready", 32'(ready), 32'h1);
    check("mid_reset_rowbias", 32'(rowbias), 32'h0);
    tick;
    reset = 1'b0;
    m_reset();
    for (int k = 0; k < GL; k++) begin
      read_slot(k, v[k]);
      check("mid_identity", 32'(v[k]), 32'h1 << k);
    end

    seen = '0;
    for (int n = 0; n < 200; n++) begin
      start_shuffle();
      m_shuffle(s1);
      wait_ready("loop", cyc);
      check("loop_cycles", 32'(cyc), 32'(s1));
      acc = '0;
      ok = 1'b1;
      code = '0;
      for (int k = 0; k < GL; k++) begin
        read_slot(k, v[k]);
        acc = acc | v[k];
        if (!$onehot(v[k])) ok = 1'b0;
        if (v[k] !== m_slot[k]) ok = 1'b0;
        code[2*k +: 2] = 2'($clog2(v[k]));
      end
      check("loop_onehot_model", 32'(ok), 32'h1);
      check("loop_or", 32'(acc), 32'hF);
      seen[code] = 1'b1;
    end
    nperm = 0;
    for (int c = 0; c < 256; c++) if (seen[c]) nperm++;
    check("perm_coverage", 32'(nperm), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
